mod_exp_ctrl: RTL

- Sequencer computing base^exponent mod (2^32-1) by left-to-right square-and-multiply.
- It time-multiplexes one external mul_mod pipeline, one operation in flight at a time.
- Sits beside mul_mod inside the SRAM process table datapath and owns its operand inputs.
- Uses a start/busy/done handshake toward the table logic.

---
 rtl/mod_exp_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for base^exponent mod (2^32-1).
// Drives one external mul_mod pipeline, keeping a single multiply in flight.
module mod_exp_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int EXP_W   = 32
) (
    input  logic             axi_aclk,
    input  logic             axi_aresetn,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [EXP_W-1:0] exponent,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic [31:0]      mul_data_1,
    output logic [31:0]      mul_data_2,
    input  logic [31:0]      mul_mod_data,
    output logic [2:0]       fsm_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy rises the
    // cycle after acceptance and falls on the same edge that raises the one-cycle done.

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam int CNT_W = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MUL_LAT);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SCAN      = 3'd1;
    localparam logic [2:0] S_SQR_ISSUE = 3'd2;
    localparam logic [2:0] S_SQR_WAIT  = 3'd3;
    localparam logic [2:0] S_MUL_ISSUE = 3'd4;
    localparam logic [2:0] S_MUL_WAIT  = 3'd5;
    localparam logic [2:0] S_STEP      = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]       state;
    logic [31:0]      acc;
    logic [31:0]      b_reg;
    logic [EXP_W-1:0] e_reg;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] top;
    logic [CNT_W-1:0] wait_cnt;

    // All-ones is the non-canonical encoding of zero modulo 2^32-1.
    function automatic logic [31:0] norm(input logic [31:0] x);
        return (x == 32'hFFFF_FFFF) ? 32'd0 : x;
    endfunction

    function automatic logic [IDX_W-1:0] msb_idx(input logic [EXP_W-1:0] v);
        logic [IDX_W-1:0] m;
        m = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (v[i]) m = IDX_W'(i);
        end
        return m;
    endfunction

    assign top       = msb_idx(e_reg);
    assign fsm_state = state;

    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= 32'd0;
            mul_data_1 <= 32'd0;
            mul_data_2 <= 32'd0;
            acc        <= 32'd0;
            b_reg      <= 32'd0;
            e_reg      <= '0;
            idx        <= '0;
            wait_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        b_reg <= norm(base);
                        e_reg <= exponent;
                        busy  <= 1'b1;
                        state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (e_reg == '0) begin
                        result <= 32'd1;
                        state  <= S_DONE;
                    end else begin
                        acc <= b_reg;
                        if (top == '0) begin
                            result <= b_reg;
                            state  <= S_DONE;
                        end else begin
                            idx   <= top - 1'b1;
                            state <= S_SQR_ISSUE;
                        end
                    end
                end
                S_SQR_ISSUE: begin
                    mul_data_1 <= acc;
                    mul_data_2 <= acc;
                    wait_cnt   <= '0;
                    state      <= S_SQR_WAIT;
                end
                S_SQR_WAIT: begin
                    // Product is valid once MUL_LAT edges have passed since the issue edge.
                    if (wait_cnt == LAT_CNT) begin
                        acc   <= norm(mul_mod_data);
                        state <= e_reg[idx] ? S_MUL_ISSUE : S_STEP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_MUL_ISSUE: begin
                    mul_data_1 <= acc;
                    mul_data_2 <= b_reg;
                    wait_cnt   <= '0;
                    state      <= S_MUL_WAIT;
                end
                S_MUL_WAIT: begin
                    if (wait_cnt == LAT_CNT) begin
                        acc   <= norm(mul_mod_data);
                        state <= S_STEP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_STEP: begin
                    if (idx == '0) begin
                        result <= acc;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= S_SQR_ISSUE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
